// File: rtl/matrix_operand_fetch.sv
// matrix_operand_fetch
// Reads general registers R0..R7 one per cycle through a register-file read
// port and packs them into the 32-bit operands A (R0..R3) and B (R4..R7)
// for the 2x2 8-bit matrix multiplier. When the last byte is captured it
// pulses operands_valid for one cycle. The fetch holds its position while
// the result write-back unit is busy.

module matrix_operand_fetch (
    input  logic        clk,
    input  logic        reset,
    input  logic        is_matrix_mult,
    input  logic        matrix_write_in_progress,
    input  logic [7:0]  rddata,
    output logic [2:0]  rdreg,
    output logic [31:0] A,
    output logic [31:0] B,
    output logic        operands_valid,
    output logic        busy
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FETCH = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [2:0]  read_counter_q, read_counter_d;
    logic [2:0]  rdreg_q, rdreg_d;
    logic [63:0] operands_q, operands_d;   // {B, A}, byte k holds Rk
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;

    logic        capture;
    logic        last_byte;
    logic [7:0]  byte_sel;

    // A byte is taken only while fetching and the write-back unit is idle.
    assign capture   = (state_q == ST_FETCH) && !matrix_write_in_progress;
    assign last_byte = (read_counter_q == 3'd7);

    // One byte lane per register: lane gi loads rddata when the counter
    // points at it, otherwise it keeps its previous contents so A/B stay
    // stable between fetches.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign byte_sel[gi] = capture && (read_counter_q == 3'(gi));
            assign operands_d[gi*8 +: 8] = byte_sel[gi] ? rddata
                                                        : operands_q[gi*8 +: 8];
        end
    endgenerate

    // Next-state logic for the IDLE/FETCH sequencer and its counters.
    always_comb begin
        state_d        = state_q;
        read_counter_d = read_counter_q;
        rdreg_d        = rdreg_q;
        busy_d         = busy_q;
        valid_d        = 1'b0;    // the pulse always drops after one cycle

        case (state_q)
            ST_IDLE: begin
                read_counter_d = 3'd0;
                rdreg_d        = 3'd0;
                busy_d         = 1'b0;
                if (is_matrix_mult) begin
                    state_d = ST_FETCH;
                    busy_d  = 1'b1;
                end
            end
            ST_FETCH: begin
                // Requests arriving here are dropped, not queued.
                if (capture) begin
                    if (last_byte) begin
                        state_d        = ST_IDLE;
                        read_counter_d = 3'd0;
                        rdreg_d        = 3'd0;
                        busy_d         = 1'b0;
                        valid_d        = 1'b1;
                    end else begin
                        read_counter_d = read_counter_q + 3'd1;
                        rdreg_d        = rdreg_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d        = ST_IDLE;
                read_counter_d = 3'd0;
                rdreg_d        = 3'd0;
                busy_d         = 1'b0;
            end
        endcase
    end

    // State registers; reset is asynchronous so a mid-fetch abort clears
    // every output immediately and discards the partial operands.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            read_counter_q <= 3'd0;
            rdreg_q        <= 3'd0;
            operands_q     <= 64'd0;
            valid_q        <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_counter_q <= read_counter_d;
            rdreg_q        <= rdreg_d;
            operands_q     <= operands_d;
            valid_q        <= valid_d;
            busy_q         <= busy_d;
        end
    end

    assign rdreg          = rdreg_q;
    assign A              = operands_q[31:0];
    assign B              = operands_q[63:32];
    assign operands_valid = valid_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_matrix_operand_fetch.sv
// Bench for matrix_operand_fetch: table-driven fetch scenarios, hand-written
// back-to-back and reset sequences, then randomized traffic compared each
// cycle against a register-level behavioural model.

module tb_matrix_operand_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        stall = 1'b0;
    logic [7:0]  rddata;
    logic [2:0]  rdreg;
    logic [31:0] A;
    logic [31:0] B;
    logic        valid;
    logic        busy;

    logic [7:0]  rf [8];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a fetch is "in progress at register m_idx";
    // each unstalled edge copies Rk into byte k of the operand pair.
    bit          m_fetch;
    int          m_idx;
    logic [7:0]  m_bytes [8];
    logic        m_valid;

    typedef struct {
        int          stall_at;
        int          stall_len;
        int          req_a;
        int          req_b;
        logic [7:0]  r0;
        int          exp_lat;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } vec_t;

    vec_t vecs [5];

    assign rddata = rf[rdreg];

    always #5 clk = ~clk;

    matrix_operand_fetch dut (
        .clk                      (clk),
        .reset                    (reset),
        .is_matrix_mult           (req),
        .matrix_write_in_progress (stall),
        .rddata                   (rddata),
        .rdreg                    (rdreg),
        .A                        (A),
        .B                        (B),
        .operands_valid           (valid),
        .busy                     (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fetch = 0;
        m_idx   = 0;
        m_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_bytes[i] = 8'h00;
    endtask

    task automatic model_edge();
        if (!reset) begin
            model_reset();
        end else begin
            m_valid = 1'b0;
            if (!m_fetch) begin
                if (req) begin
                    m_fetch = 1;
                    m_idx   = 0;
                end
            end else if (!stall) begin
                m_bytes[m_idx] = rf[m_idx];
                if (m_idx == 7) begin
                    m_fetch = 0;
                    m_idx   = 0;
                    m_valid = 1'b1;
                end else begin
                    m_idx = m_idx + 1;
                end
            end
        end
    endtask

    task automatic compare_model();
        check("rdreg", 64'(rdreg), 64'(m_idx));
        check("A", 64'(A), 64'({m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]}));
        check("B", 64'(B), 64'({m_bytes[7], m_bytes[6], m_bytes[5], m_bytes[4]}));
        check("operands_valid", 64'(valid), 64'(m_valid));
        check("busy", 64'(busy), 64'(m_fetch));
    endtask

    // One clock: model sees the same inputs as the DUT at the edge,
    // outputs are compared 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic load_rf(input logic [7:0] r0);
        for (int i = 0; i < 8; i++) rf[i] = 8'((i + 1) * 17);
        rf[0] = r0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            tick();
            if (valid) begin
                lat = cyc;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (valid) pulses++;
        end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        int busy_cnt;
        int stalls;
        int extra;
        logic [31:0] got_a;
        logic [31:0] got_b;
        load_rf(v.r0);
        req = 1'b1;
        tick();
        req = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat = -1;
        stalls = 0;
        got_a = 32'h0;
        got_b = 32'h0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            req   = (cyc == v.req_a) || (cyc == v.req_b);
            stall = (v.stall_at >= 0) && (rdreg == 3'(v.stall_at)) && (stalls < v.stall_len);
            if (stall) stalls++;
            tick();
            if (busy) busy_cnt++;
            if (valid) begin
                lat   = cyc;
                got_a = A;
                got_b = B;
                break;
            end
        end
        req   = 1'b0;
        stall = 1'b0;
        check($sformatf("vec%0d latency", idx), 64'(lat), 64'(v.exp_lat));
        check($sformatf("vec%0d A", idx), 64'(got_a), 64'(v.exp_a));
        check($sformatf("vec%0d B", idx), 64'(got_b), 64'(v.exp_b));
        check($sformatf("vec%0d busy_cycles", idx), 64'(busy_cnt), 64'(v.exp_lat));
        count_pulses(10, extra);
        check($sformatf("vec%0d extra_pulses", idx), 64'(extra), 64'd0);
        $display("vec%0d: latency %0d A=%h B=%h", idx, lat, got_a, got_b);
    endtask

    initial begin
        int lat;
        int pulses;

        // stall_at, stall_len, req_a, req_b, r0, latency, A, B
        vecs[0] = '{-1, 0, -1, -1, 8'h11,  8, 32'h44332211, 32'h88776655};
        vecs[1] = '{ 2, 3, -1, -1, 8'h11, 11, 32'h44332211, 32'h88776655};
        vecs[2] = '{-1, 0,  3,  8, 8'h11,  8, 32'h44332211, 32'h88776655};
        vecs[3] = '{ 7, 2, -1, -1, 8'h5A, 10, 32'h4433225A, 32'h88776655};
        vecs[4] = '{ 0, 1,  5, -1, 8'hC3,  9, 32'h443322C3, 32'h88776655};

        load_rf(8'h11);
        model_reset();

        // Reset values, checked without any clock edge.
        #2 reset = 1'b0;
        #1;
        check("rst rdreg", 64'(rdreg), 64'd0);
        check("rst A", 64'(A), 64'd0);
        check("rst B", 64'(B), 64'd0);
        check("rst valid", 64'(valid), 64'd0);
        check("rst busy", 64'(busy), 64'd0);
        $display("reset: rdreg=%0d A=%h B=%h valid=%b busy=%b", rdreg, A, B, valid, busy);
        tick();
        tick();
        reset = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // Back-to-back: request during the operands_valid cycle.
        load_rf(8'h11);
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_valid(lat);
        check("b2b first latency", 64'(lat), 64'd8);
        rf[0] = 8'hA5;
        req = 1'b1;
        tick();
        req = 1'b0;
        check("b2b accepted", 64'(busy), 64'd1);
        wait_valid(lat);
        check("b2b second latency", 64'(lat), 64'd8);
        check("b2b A", 64'(A), 64'h443322A5);
        check("b2b B", 64'(B), 64'h88776655);
        $display("b2b: latency %0d A=%h B=%h", lat, A, B);

        // Reset while rdreg = 5.
        load_rf(8'h11);
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 10 && rdreg != 3'd5; i++) tick();
        check("pre-abort rdreg", 64'(rdreg), 64'd5);
        reset = 1'b0;
        #1;
        check("abort rdreg", 64'(rdreg), 64'd0);
        check("abort A", 64'(A), 64'd0);
        check("abort B", 64'(B), 64'd0);
        check("abort valid", 64'(valid), 64'd0);
        check("abort busy", 64'(busy), 64'd0);
        model_reset();
        tick();
        tick();
        reset = 1'b1;
        count_pulses(12, pulses);
        check("abort no pulse", 64'(pulses), 64'd0);
        load_rf(8'h3C);
        req = 1'b1;
        tick();
        req = 1'b0;
        wait_valid(lat);
        check("post-abort latency", 64'(lat), 64'd8);
        check("post-abort A", 64'(A), 64'h4433223C);
        check("post-abort B", 64'(B), 64'h88776655);
        $display("abort: refetch latency %0d A=%h B=%h", lat, A, B);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            req   = ($urandom_range(0, 3) == 0);
            stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) rf[$urandom_range(0, 7)] = 8'($urandom);
            reset = ($urandom_range(0, 99) != 0);
            tick();
            if (valid) $display("random: pulse A=%h B=%h", A, B);
        end
        reset = 1'b1;
        req   = 1'b0;
        stall = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
